// File: rtl/fifo_read_streamer_if.sv
// fifo_read_streamer_if
//   Output stream of the FIFO read streamer: registered data plus a
//   valid/ready handshake. A word transfers on a cycle where doutValid and
//   doutReady are both high.
// Signals
//   dout       DATA_W  stream data, held stable while doutValid is high
//   doutValid  1       stream valid
//   doutReady  1       downstream accepts dout this cycle
// Modports
//   master  producer side (the streamer)
//   slave   consumer side (display / serial logic)
interface fifo_read_streamer_if #(
    parameter int unsigned DATA_W = 8
) ();

    logic [DATA_W-1:0] dout;
    logic              doutValid;
    logic              doutReady;

    modport master (
        output dout,
        output doutValid,
        input  doutReady
    );

    modport slave (
        input  dout,
        input  doutValid,
        output doutReady
    );

endinterface

// File: rtl/fifo_read_streamer.sv
// fifo_read_streamer
//   Read-side consumer of the 64-entry data FIFO. Keeps its own read pointer
//   (with wrap bit) against the writer's pointer, fetches words from the FIFO
//   RAM (one cycle read latency) and presents them on a valid/ready stream.
// Ports
//   clock      single clock, posedge
//   reset      synchronous, active-high; wins over everything
//   enable     drain enable; low stops new fetches (a held word still drains)
//   writePtr   writer pointer incl. wrap bit, ADDR_W+1 bits
//   ramData    RAM read data, valid one cycle after re
//   re         RAM read strobe (combinational)
//   ramAddr    RAM read address, low ADDR_W bits of the read pointer
//   empty      writePtr == readPtr (combinational)
//   count      writePtr - readPtr, words still in RAM (0..DEPTH)
//   wordsRead  handshake counter, only with FIFO_READ_STREAMER_STATS_EN
//   strm       output stream (master modport of fifo_read_streamer_if)
// Configuration
//   FIFO_READ_STREAMER_STATS_EN  adds the 16-bit wrapping wordsRead counter.
module fifo_read_streamer #(
    parameter int unsigned DATA_W = 8,
    parameter int unsigned ADDR_W = 6
) (
    input  logic              clock,
    input  logic              reset,
    input  logic              enable,
    input  logic [ADDR_W:0]   writePtr,
    input  logic [DATA_W-1:0] ramData,
    output logic              re,
    output logic [ADDR_W-1:0] ramAddr,
    output logic              empty,
    output logic [ADDR_W:0]   count,
`ifdef FIFO_READ_STREAMER_STATS_EN
    output logic [15:0]       wordsRead,
`endif
    fifo_read_streamer_if.master strm
);

    typedef enum logic [1:0] {
        StIdle,
        StFetch,
        StHold
    } state_e;

    state_e            state_q, state_d;
    logic [ADDR_W:0]   rd_ptr_q, rd_ptr_d;
    logic [DATA_W-1:0] dout_q, dout_d;
    logic              valid_q, valid_d;
    logic              re_fsm;
    logic              issue_ok;
    logic              handshake;

    // Wrap bit distinguishes full (count == DEPTH) from empty.
    assign empty     = (writePtr == rd_ptr_q);
    assign count     = writePtr - rd_ptr_q;
    assign ramAddr   = rd_ptr_q[ADDR_W-1:0];
    assign issue_ok  = enable && !empty;
    assign handshake = valid_q && strm.doutReady;

    // The RAM must never see a read while reset is high.
    assign re = re_fsm && !reset;

    assign strm.dout      = dout_q;
    assign strm.doutValid = valid_q;

    always_comb begin
        state_d  = state_q;
        rd_ptr_d = rd_ptr_q;
        dout_d   = dout_q;
        valid_d  = valid_q;
        re_fsm   = 1'b0;
        unique case (state_q)
            StIdle: begin
                if (issue_ok) begin
                    re_fsm   = 1'b1;
                    rd_ptr_d = rd_ptr_q + 1'b1;
                    state_d  = StFetch;
                end
            end
            StFetch: begin
                // RAM data for the address issued last cycle is valid now.
                dout_d  = ramData;
                valid_d = 1'b1;
                state_d = StHold;
            end
            StHold: begin
                if (handshake) begin
                    valid_d = 1'b0;
                    // Back-to-back issue on the accept cycle: 2 cycles/word.
                    if (issue_ok) begin
                        re_fsm   = 1'b1;
                        rd_ptr_d = rd_ptr_q + 1'b1;
                        state_d  = StFetch;
                    end else begin
                        state_d = StIdle;
                    end
                end
            end
            default: begin
                state_d = StIdle;
                valid_d = 1'b0;
            end
        endcase
    end

    always_ff @(posedge clock) begin
        if (reset) begin
            state_q  <= StIdle;
            rd_ptr_q <= '0;
            dout_q   <= '0;
            valid_q  <= 1'b0;
        end else begin
            state_q  <= state_d;
            rd_ptr_q <= rd_ptr_d;
            dout_q   <= dout_d;
            valid_q  <= valid_d;
        end
    end

`ifdef FIFO_READ_STREAMER_STATS_EN
    logic [15:0] words_q;

    always_ff @(posedge clock) begin
        if (reset) begin
            words_q <= '0;
        end else if (handshake) begin
            words_q <= words_q + 16'd1;
        end
    end

    assign wordsRead = words_q;
`endif

endmodule
